// File: rtl/i3c_fifo_level_track_if.sv
// Handshake bundle between the APB/bus-engine FIFO strobes and the level tracker.
// The tracker side uses the slave modport; the strobe source uses master.
interface i3c_fifo_level_track_if #(
  parameter int CNT_W = 7
);
  logic             rx_push;
  logic [1:0]       rx_pop;
  logic [1:0]       tx_push;
  logic             tx_pop;
  logic             rx_flush;
  logic             tx_flush;
  logic [1:0]       rx_trig_lvl;
  logic [1:0]       tx_trig_lvl;
  logic             err_clr;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] tx_cnt;
  logic [1:0]       rx_fullness;
  logic [1:0]       tx_avail;
  logic             rx_trig;
  logic             tx_trig;
  logic             rx_full;
  logic             tx_empty;
  logic             rx_ovf;
  logic             rx_unf;
  logic             tx_ovf;
  logic             tx_unf;

  modport master (
    output rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush,
           rx_trig_lvl, tx_trig_lvl, err_clr,
    input  rx_cnt, tx_cnt, rx_fullness, tx_avail, rx_trig, tx_trig,
           rx_full, tx_empty, rx_ovf, rx_unf, tx_ovf, tx_unf
  );

  modport slave (
    input  rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush,
           rx_trig_lvl, tx_trig_lvl, err_clr,
    output rx_cnt, tx_cnt, rx_fullness, tx_avail, rx_trig, tx_trig,
           rx_full, tx_empty, rx_ovf, rx_unf, tx_ovf, tx_unf
  );
endinterface

// File: rtl/i3c_fifo_level_track.sv
// RX/TX FIFO occupancy tracker feeding the DMA request controller: counts,
// saturating error handling, sticky error flags and threshold-crossing pulses.
module i3c_fifo_level_track #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int CNT_W    = 7
) (
  input logic PCLK,
  input logic PRESETn,
  i3c_fifo_level_track_if.slave bus
);

  localparam logic [CNT_W-1:0] RX_D = CNT_W'(RX_DEPTH);
  localparam logic [CNT_W-1:0] TX_D = CNT_W'(TX_DEPTH);

  // Pop/push size code: 3 is reserved and behaves as no transfer.
  function automatic logic [CNT_W-1:0] xfer_size(input logic [1:0] code);
    case (code)
      2'd1:    return CNT_W'(1);
      2'd2:    return CNT_W'(2);
      default: return '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] level_bytes(input logic [1:0] code,
                                                   input logic [CNT_W-1:0] depth);
    case (code)
      2'd0:    return CNT_W'(1);
      2'd1:    return depth >> 2;
      2'd2:    return depth >> 1;
      default: return (depth >> 1) + (depth >> 2);
    endcase
  endfunction

  logic [CNT_W-1:0] rx_cnt, tx_cnt;
  logic             rx_trig, tx_trig;
  logic             rx_ovf, rx_unf, tx_ovf, tx_unf;

  logic [CNT_W-1:0] rx_pop_sz, rx_nxt, rx_thr;
  logic [CNT_W:0]   rx_sum;
  logic             rx_ovf_set, rx_unf_set, rx_trig_nxt;

  logic [CNT_W-1:0] tx_push_sz, tx_nxt, tx_thr, tx_free, tx_free_nxt;
  logic [CNT_W:0]   tx_room, tx_sum;
  logic             tx_ovf_set, tx_unf_set, tx_trig_nxt;

  always_comb begin
    rx_pop_sz  = xfer_size(bus.rx_pop);
    rx_sum     = {1'b0, rx_cnt} + {{CNT_W{1'b0}}, bus.rx_push};
    rx_nxt     = rx_cnt;
    rx_ovf_set = 1'b0;
    rx_unf_set = 1'b0;
    if (bus.rx_flush) begin
      rx_nxt = '0;
    end else if (bus.rx_push && (rx_cnt == RX_D) && (rx_pop_sz == '0)) begin
      rx_ovf_set = 1'b1;
    end else if ({1'b0, rx_pop_sz} > rx_sum) begin
      rx_nxt     = '0;
      rx_unf_set = 1'b1;
    end else begin
      rx_nxt = CNT_W'(rx_sum - {1'b0, rx_pop_sz});
    end
  end

  // Room accounts for a same-cycle bus-engine pop freeing one more byte.
  always_comb begin
    tx_push_sz = xfer_size(bus.tx_push);
    tx_room    = {1'b0, TX_D - tx_cnt} + {{CNT_W{1'b0}}, bus.tx_pop};
    tx_sum     = {1'b0, tx_cnt} + {1'b0, tx_push_sz};
    tx_nxt     = tx_cnt;
    tx_ovf_set = 1'b0;
    tx_unf_set = 1'b0;
    if (bus.tx_flush) begin
      tx_nxt = '0;
    end else if (bus.tx_pop && (tx_cnt == '0) && (tx_push_sz == '0)) begin
      tx_unf_set = 1'b1;
    end else if ({1'b0, tx_push_sz} > tx_room) begin
      tx_nxt     = TX_D;
      tx_ovf_set = 1'b1;
    end else begin
      tx_nxt = CNT_W'(tx_sum - {{CNT_W{1'b0}}, bus.tx_pop});
    end
  end

  always_comb begin
    rx_thr      = level_bytes(bus.rx_trig_lvl, RX_D);
    rx_trig_nxt = !bus.rx_flush && (rx_nxt >= rx_thr) && (rx_cnt < rx_thr);
    tx_thr      = level_bytes(bus.tx_trig_lvl, TX_D);
    tx_free     = TX_D - tx_cnt;
    tx_free_nxt = TX_D - tx_nxt;
    tx_trig_nxt = !bus.tx_flush && (tx_free_nxt >= tx_thr) && (tx_free < tx_thr);
  end

  // Error flags are sticky; a new error in the clearing cycle keeps the flag.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rx_cnt  <= '0;
      tx_cnt  <= '0;
      rx_trig <= 1'b0;
      tx_trig <= 1'b0;
      rx_ovf  <= 1'b0;
      rx_unf  <= 1'b0;
      tx_ovf  <= 1'b0;
      tx_unf  <= 1'b0;
    end else begin
      rx_cnt  <= rx_nxt;
      tx_cnt  <= tx_nxt;
      rx_trig <= rx_trig_nxt;
      tx_trig <= tx_trig_nxt;
      rx_ovf  <= rx_ovf_set | (rx_ovf & ~bus.err_clr);
      rx_unf  <= rx_unf_set | (rx_unf & ~bus.err_clr);
      tx_ovf  <= tx_ovf_set | (tx_ovf & ~bus.err_clr);
      tx_unf  <= tx_unf_set | (tx_unf & ~bus.err_clr);
    end
  end

  assign bus.rx_cnt      = rx_cnt;
  assign bus.tx_cnt      = tx_cnt;
  assign bus.rx_fullness = (rx_cnt > CNT_W'(3)) ? 2'd3 : rx_cnt[1:0];
  assign bus.tx_avail    = (tx_free > CNT_W'(3)) ? 2'd3 : tx_free[1:0];
  assign bus.rx_full     = (rx_cnt == RX_D);
  assign bus.tx_empty    = (tx_cnt == '0);
  assign bus.rx_trig     = rx_trig;
  assign bus.tx_trig     = tx_trig;
  assign bus.rx_ovf      = rx_ovf;
  assign bus.rx_unf      = rx_unf;
  assign bus.tx_ovf      = tx_ovf;
  assign bus.tx_unf      = tx_unf;

endmodule

// File: tb/tb_i3c_fifo_level_track.sv
// Bench for i3c_fifo_level_track: directed scenarios plus randomized traffic
// checked against an integer occupancy model.
module tb_i3c_fifo_level_track;

  localparam int RXD = 8;
  localparam int TXD = 8;
  localparam int CW  = 7;

  logic PCLK;
  logic PRESETn;
  int   total  = 0;
  int   passed = 0;

  int m_rx, m_tx;
  bit m_rx_trig, m_tx_trig, m_rx_ovf, m_rx_unf, m_tx_ovf, m_tx_unf;

  i3c_fifo_level_track_if #(.CNT_W(CW)) bus ();

  i3c_fifo_level_track #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .CNT_W(CW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic int thr_of(input logic [1:0] code, input int depth);
    return (code == 2'd0) ? 1 : (int'(code) * depth) / 4;
  endfunction

  function automatic int size_of(input logic [1:0] code);
    return (code == 2'd3) ? 0 : int'(code);
  endfunction

  function automatic int min3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic idle();
    bus.rx_push  = 1'b0;
    bus.rx_pop   = 2'd0;
    bus.tx_push  = 2'd0;
    bus.tx_pop   = 1'b0;
    bus.rx_flush = 1'b0;
    bus.tx_flush = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  // Advance the model from the current inputs, then clock the DUT once.
  task automatic tick();
    int rx_new, tx_new, rthr, tthr;
    bit ro, ru, to, tu;
    ro = 0; ru = 0; to = 0; tu = 0;
    if (!PRESETn) begin
      m_rx = 0; m_tx = 0;
      m_rx_trig = 0; m_tx_trig = 0;
      m_rx_ovf = 0; m_rx_unf = 0; m_tx_ovf = 0; m_tx_unf = 0;
    end else begin
      rthr = thr_of(bus.rx_trig_lvl, RXD);
      tthr = thr_of(bus.tx_trig_lvl, TXD);
      if (bus.rx_flush) rx_new = 0;
      else if (bus.rx_push && m_rx == RXD && size_of(bus.rx_pop) == 0) begin
        rx_new = m_rx; ro = 1;
      end else begin
        rx_new = m_rx + int'(bus.rx_push) - size_of(bus.rx_pop);
        if (rx_new < 0) begin rx_new = 0; ru = 1; end
      end
      if (bus.tx_flush) tx_new = 0;
      else if (bus.tx_pop && m_tx == 0 && size_of(bus.tx_push) == 0) begin
        tx_new = 0; tu = 1;
      end else begin
        tx_new = m_tx + size_of(bus.tx_push) - int'(bus.tx_pop);
        if (tx_new > TXD) begin tx_new = TXD; to = 1; end
      end
      m_rx_trig = !bus.rx_flush && rx_new >= rthr && m_rx < rthr;
      m_tx_trig = !bus.tx_flush && (TXD - tx_new) >= tthr && (TXD - m_tx) < tthr;
      m_rx_ovf = ro || (m_rx_ovf && !bus.err_clr);
      m_rx_unf = ru || (m_rx_unf && !bus.err_clr);
      m_tx_ovf = to || (m_tx_ovf && !bus.err_clr);
      m_tx_unf = tu || (m_tx_unf && !bus.err_clr);
      m_rx = rx_new;
      m_tx = tx_new;
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.rx_trig_lvl = 2'd0;
    bus.tx_trig_lvl = 2'd0;
    PRESETn = 1'b0;
    tick(); tick();
    PRESETn = 1'b1;
    total++;
    if ({bus.rx_cnt, bus.tx_cnt} !== {7'd0, 7'd0})
      $display("[TB] FAIL reset_counts got rx=%0d tx=%0d exp 0/0", bus.rx_cnt, bus.tx_cnt);
    else passed++;
    total++;
    if ({bus.rx_fullness, bus.tx_avail, bus.rx_full, bus.tx_empty} !== {2'd0, 2'd3, 1'b0, 1'b1})
      $display("[TB] FAIL reset_derived got full=%0d avail=%0d rxf=%0b txe=%0b exp 0/3/0/1",
               bus.rx_fullness, bus.tx_avail, bus.rx_full, bus.tx_empty);
    else passed++;
    total++;
    if ({bus.rx_trig, bus.tx_trig, bus.rx_ovf, bus.rx_unf, bus.tx_ovf, bus.tx_unf} !== 6'b0)
      $display("[TB] FAIL reset_flags got %b exp 000000",
               {bus.rx_trig, bus.tx_trig, bus.rx_ovf, bus.rx_unf, bus.tx_ovf, bus.tx_unf});
    else passed++;
  endtask

  task automatic test_rx_push_trig();
    idle();
    bus.rx_trig_lvl = 2'd1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_push = 1'b1;
      tick();
      total++;
      if (bus.rx_cnt !== 7'(i + 1) || bus.rx_fullness !== 2'(i + 1))
        $display("[TB] FAIL rx_push_cnt step=%0d got cnt=%0d full=%0d exp %0d",
                 i, bus.rx_cnt, bus.rx_fullness, i + 1);
      else passed++;
      total++;
      if (bus.rx_trig !== (i == 1))
        $display("[TB] FAIL rx_push_trig step=%0d got %0b exp %0b", i, bus.rx_trig, i == 1);
      else passed++;
    end
    idle();
  endtask

  task automatic test_rx_overflow();
    idle();
    bus.rx_push = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tick();
    total++;
    if (bus.rx_cnt !== 7'd8 || bus.rx_ovf !== 1'b1 || bus.rx_full !== 1'b1)
      $display("[TB] FAIL rx_ovf got cnt=%0d ovf=%0b full=%0b exp 8/1/1",
               bus.rx_cnt, bus.rx_ovf, bus.rx_full);
    else passed++;
    bus.rx_pop = 2'd2;
    tick();
    total++;
    if (bus.rx_cnt !== 7'd7)
      $display("[TB] FAIL rx_full_push_hw_pop got %0d exp 7", bus.rx_cnt);
    else passed++;
    idle();
    bus.err_clr = 1'b1;
    tick();
    idle();
    total++;
    if (bus.rx_ovf !== 1'b0)
      $display("[TB] FAIL rx_ovf_clr got %0b exp 0", bus.rx_ovf);
    else passed++;
  endtask

  task automatic test_rx_underflow();
    idle();
    bus.rx_flush = 1'b1;
    tick();
    idle();
    bus.rx_push = 1'b1;
    tick();
    idle();
    bus.rx_pop = 2'd2;
    tick();
    total++;
    if (bus.rx_cnt !== 7'd0 || bus.rx_unf !== 1'b1 || bus.rx_fullness !== 2'd0)
      $display("[TB] FAIL rx_unf got cnt=%0d unf=%0b full=%0d exp 0/1/0",
               bus.rx_cnt, bus.rx_unf, bus.rx_fullness);
    else passed++;
    bus.rx_pop  = 2'd1;
    bus.err_clr = 1'b1;
    tick();
    total++;
    if (bus.rx_unf !== 1'b1)
      $display("[TB] FAIL rx_unf_set_wins got %0b exp 1", bus.rx_unf);
    else passed++;
    idle();
    bus.err_clr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_tx_overflow();
    idle();
    bus.tx_push = 2'd2;
    for (int i = 0; i < 3; i++) tick();
    bus.tx_push = 2'd1;
    tick();
    bus.tx_push = 2'd2;
    tick();
    total++;
    if (bus.tx_cnt !== 7'd8 || bus.tx_ovf !== 1'b1 || bus.tx_avail !== 2'd0)
      $display("[TB] FAIL tx_ovf got cnt=%0d ovf=%0b avail=%0d exp 8/1/0",
               bus.tx_cnt, bus.tx_ovf, bus.tx_avail);
    else passed++;
    idle();
    bus.tx_flush = 1'b1;
    bus.err_clr  = 1'b1;
    tick();
    idle();
    total++;
    if (bus.tx_cnt !== 7'd0 || bus.tx_ovf !== 1'b0 || bus.tx_trig !== 1'b0)
      $display("[TB] FAIL tx_flush_clr got cnt=%0d ovf=%0b trig=%0b exp 0/0/0",
               bus.tx_cnt, bus.tx_ovf, bus.tx_trig);
    else passed++;
  endtask

  task automatic test_tx_trig();
    idle();
    bus.tx_trig_lvl = 2'd2;
    bus.tx_push = 2'd2;
    for (int i = 0; i < 3; i++) tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.tx_pop = 1'b1;
      tick();
      total++;
      if (bus.tx_cnt !== 7'(5 - i) || bus.tx_avail !== 2'd3)
        $display("[TB] FAIL tx_pop_cnt step=%0d got cnt=%0d avail=%0d exp %0d/3",
                 i, bus.tx_cnt, bus.tx_avail, 5 - i);
      else passed++;
      total++;
      if (bus.tx_trig !== (i == 1))
        $display("[TB] FAIL tx_trig step=%0d got %0b exp %0b", i, bus.tx_trig, i == 1);
      else passed++;
    end
    idle();
  endtask

  task automatic test_flush_and_reset();
    idle();
    bus.rx_push = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.rx_flush = 1'b1;
    bus.rx_pop   = 2'd1;
    tick();
    idle();
    total++;
    if ({bus.rx_cnt, bus.rx_trig, bus.rx_ovf, bus.rx_unf, bus.tx_ovf, bus.tx_unf} !== {7'd0, 5'b0})
      $display("[TB] FAIL rx_flush got cnt=%0d trig=%0b flags=%b exp 0/0/0000", bus.rx_cnt,
               bus.rx_trig, {bus.rx_ovf, bus.rx_unf, bus.tx_ovf, bus.tx_unf});
    else passed++;
    bus.tx_push = 2'd1;
    tick();
    idle();
    total++;
    if (bus.tx_cnt !== 7'd3)
      $display("[TB] FAIL tx_pre_reset got %0d exp 3", bus.tx_cnt);
    else passed++;
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    total++;
    if (bus.tx_cnt !== 7'd0 || bus.tx_empty !== 1'b1)
      $display("[TB] FAIL tx_reset got cnt=%0d empty=%0b exp 0/1", bus.tx_cnt, bus.tx_empty);
    else passed++;
  endtask

  task automatic test_random();
    logic [6:0] exp_rx, exp_tx;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.rx_push  = 1'($urandom_range(0, 1));
      bus.rx_pop   = 2'($urandom_range(0, 3));
      bus.tx_push  = 2'($urandom_range(0, 3));
      bus.tx_pop   = 1'($urandom_range(0, 1));
      bus.rx_flush = ($urandom_range(0, 19) == 0);
      bus.tx_flush = ($urandom_range(0, 19) == 0);
      bus.err_clr  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) bus.rx_trig_lvl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.tx_trig_lvl = 2'($urandom_range(0, 3));
      PRESETn = ($urandom_range(0, 149) != 0);
      tick();
      exp_rx = 7'(m_rx);
      exp_tx = 7'(m_tx);
      total++;
      if (bus.rx_cnt !== exp_rx || bus.tx_cnt !== exp_tx)
        $display("[TB] FAIL rand_cnt cyc=%0d got rx=%0d tx=%0d exp rx=%0d tx=%0d",
                 cyc, bus.rx_cnt, bus.tx_cnt, m_rx, m_tx);
      else passed++;
      total++;
      if (bus.rx_fullness !== 2'(min3(m_rx)) || bus.tx_avail !== 2'(min3(TXD - m_tx)) ||
          bus.rx_full !== (m_rx == RXD) || bus.tx_empty !== (m_tx == 0))
        $display("[TB] FAIL rand_derived cyc=%0d got %0d/%0d/%0b/%0b exp %0d/%0d/%0b/%0b", cyc,
                 bus.rx_fullness, bus.tx_avail, bus.rx_full, bus.tx_empty,
                 min3(m_rx), min3(TXD - m_tx), m_rx == RXD, m_tx == 0);
      else passed++;
      total++;
      if (bus.rx_trig !== m_rx_trig || bus.tx_trig !== m_tx_trig)
        $display("[TB] FAIL rand_trig cyc=%0d got rx=%0b tx=%0b exp rx=%0b tx=%0b",
                 cyc, bus.rx_trig, bus.tx_trig, m_rx_trig, m_tx_trig);
      else passed++;
      total++;
      if ({bus.rx_ovf, bus.rx_unf, bus.tx_ovf, bus.tx_unf} !==
          {m_rx_ovf, m_rx_unf, m_tx_ovf, m_tx_unf})
        $display("[TB] FAIL rand_flags cyc=%0d got %b exp %b", cyc,
                 {bus.rx_ovf, bus.rx_unf, bus.tx_ovf, bus.tx_unf},
                 {m_rx_ovf, m_rx_unf, m_tx_ovf, m_tx_unf});
      else passed++;
    end
    PRESETn = 1'b1;
    idle();
  endtask

  initial begin
    PRESETn = 1'b0;
    idle();
    bus.rx_trig_lvl = 2'd0;
    bus.tx_trig_lvl = 2'd0;
    test_reset();
    test_rx_push_trig();
    test_rx_overflow();
    test_rx_underflow();
    test_tx_overflow();
    test_tx_trig();
    test_flush_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
